// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: block-size helper, stream FSM states, bit-reverse helper.
package fft_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  function automatic int unsigned num_points(input int unsigned npoint);
    return 32'd1 << npoint;
  endfunction

  // Reverses the low 'bits' bits of value; higher bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned bits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) r[5'(bits - 1 - i)] = value[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_index.sv
// Combinational NPOINT-bit index bit-reversal used to restore natural bin order.
module fft_bitrev_index
  import fft_pkg::*;
#(
  parameter int unsigned NPOINT = 3
) (
  input  logic [NPOINT-1:0] idx_in,
  output logic [NPOINT-1:0] idx_out
);

  always_comb begin
    idx_out = NPOINT'(bitrev(32'(idx_in), NPOINT));
  end

endmodule

// File: rtl/fft_dout_serializer.sv
// Parallel-to-serial output stage of the FFT pipeline (one complex sample per cycle).
// Define FFT_SER_BITREV_EN to emit bins in bit-reversed capture order (natural frequency order).
module fft_dout_serializer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NPOINT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         par_valid,
  output logic                         par_busy,
  input  logic [WIDTH*(2**NPOINT)-1:0] par_real,
  input  logic [WIDTH*(2**NPOINT)-1:0] par_imag,
  output logic                         ser_valid,
  input  logic                         ser_busy,
  output logic [WIDTH-1:0]             ser_real,
  output logic [WIDTH-1:0]             ser_imag,
  output logic [NPOINT-1:0]            ser_index,
  output logic                         ser_last
);

  localparam int unsigned       NUM      = num_points(NPOINT);
  localparam logic [NPOINT-1:0] CNT_LAST = NPOINT'(NUM - 1);

  ser_state_t state, state_nxt;
  logic [NPOINT-1:0]    cnt, cnt_nxt;
  logic [WIDTH*NUM-1:0] cap_real, cap_imag;
  logic [WIDTH*NUM-1:0] src_real, src_imag;
  logic [NPOINT-1:0]    sel_cnt, order_idx;
  logic [WIDTH-1:0]     sample_real, sample_imag;
  logic                 capture, load;
  logic                 busy_nxt, valid_nxt, last_nxt;
  logic [WIDTH-1:0]     real_nxt, imag_nxt;
  logic [NPOINT-1:0]    index_nxt;

`ifdef FFT_SER_BITREV_EN
  fft_bitrev_index #(.NPOINT(NPOINT)) u_bitrev (
    .idx_in  (sel_cnt),
    .idx_out (order_idx)
  );
`else
  assign order_idx = sel_cnt;
`endif

  // In IDLE the first sample is loaded on the capture edge, so read the live bus.
  always_comb begin
    sel_cnt  = (state == STREAM) ? cnt + 1'b1 : '0;
    src_real = (state == IDLE) ? par_real : cap_real;
    src_imag = (state == IDLE) ? par_imag : cap_imag;
  end

  always_comb begin
    sample_real = '0;
    sample_imag = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (order_idx == NPOINT'(k)) begin
        sample_real = src_real[k*WIDTH +: WIDTH];
        sample_imag = src_imag[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = par_busy;
    valid_nxt = ser_valid;
    last_nxt  = ser_last;
    capture   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (par_valid && !par_busy) begin
          capture   = 1'b1;
          load      = 1'b1;
          busy_nxt  = 1'b1;
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (ser_valid && !ser_busy) begin
          if (cnt == CNT_LAST) begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            load     = 1'b1;
            cnt_nxt  = cnt + 1'b1;
            last_nxt = (cnt_nxt == CNT_LAST);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    real_nxt  = load ? sample_real : ser_real;
    imag_nxt  = load ? sample_imag : ser_imag;
    index_nxt = load ? order_idx : ser_index;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_real  <= '0;
      cap_imag  <= '0;
      par_busy  <= 1'b0;
      ser_valid <= 1'b0;
      ser_real  <= '0;
      ser_imag  <= '0;
      ser_index <= '0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      if (capture) begin
        cap_real <= par_real;
        cap_imag <= par_imag;
      end
      par_busy  <= busy_nxt;
      ser_valid <= valid_nxt;
      ser_real  <= real_nxt;
      ser_imag  <= imag_nxt;
      ser_index <= index_nxt;
      ser_last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_fft_dout_serializer.sv
// Directed bench for fft_dout_serializer with a sample scoreboard (honours FFT_SER_BITREV_EN).
module tb_fft_dout_serializer;

  localparam int unsigned W  = 16;
  localparam int unsigned NP = 3;
  localparam int unsigned N  = 8;

  typedef struct {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [NP-1:0] idx;
    logic          last;
  } smp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           par_valid;
  logic           par_busy;
  logic [W*N-1:0] par_real;
  logic [W*N-1:0] par_imag;
  logic           ser_valid;
  logic           ser_busy;
  logic [W-1:0]   ser_real;
  logic [W-1:0]   ser_imag;
  logic [NP-1:0]  ser_index;
  logic           ser_last;

  smp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;

  fft_dout_serializer #(.WIDTH(W), .NPOINT(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .par_valid (par_valid),
    .par_busy  (par_busy),
    .par_real  (par_real),
    .par_imag  (par_imag),
    .ser_valid (ser_valid),
    .ser_busy  (ser_busy),
    .ser_real  (ser_real),
    .ser_imag  (ser_imag),
    .ser_index (ser_index),
    .ser_last  (ser_last)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] order(input int unsigned c);
    logic [NP-1:0] v;
    logic [NP-1:0] r;
    v = NP'(c);
`ifdef FFT_SER_BITREV_EN
    for (int i = 0; i < NP; i++) r[i] = v[NP-1-i];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int base);
    for (int k = 0; k < N; k++) begin
      par_real[k*W +: W] = W'(base + k + 1);
      par_imag[k*W +: W] = W'(-(base + k + 1));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      cyc();
      if (sb.size() == 0 && !ser_valid) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Scoreboard: block expected on an accepted offer, each serial beat checked against the head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ser_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected ser_valid", 32'(ser_valid), 32'd0);
        end else begin
          chk("ser_real", 32'(ser_real), 32'(sb[0].re));
          chk("ser_imag", 32'(ser_imag), 32'(sb[0].im));
          chk("ser_index", 32'(ser_index), 32'(sb[0].idx));
          chk("ser_last", 32'(ser_last), 32'(sb[0].last));
          if (!ser_busy) begin
            void'(sb.pop_front());
            n_pop++;
          end
        end
      end
      if (par_valid && !par_busy) begin
        for (int k = 0; k < N; k++) begin
          smp_t s;
          s.idx  = order(k);
          s.re   = par_real[int'(s.idx)*W +: W];
          s.im   = par_imag[int'(s.idx)*W +: W];
          s.last = (k == N - 1);
          sb.push_back(s);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, captures, lows;
    rst_n = 1'b0; par_valid = 1'b0; ser_busy = 1'b0;
    fill(0);
    repeat (3) cyc();
    chk("rst par_busy", 32'(par_busy), 0);
    chk("rst ser_valid", 32'(ser_valid), 0);
    chk("rst ser_real", 32'(ser_real), 0);
    chk("rst ser_imag", 32'(ser_imag), 0);
    chk("rst ser_index", 32'(ser_index), 0);
    chk("rst ser_last", 32'(ser_last), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // 1: single block, no stalls
    par_valid = 1'b1;
    cyc();
    par_valid = 1'b0;
    chk("t1 latency ser_valid", 32'(ser_valid), 1);
    chk("t1 par_busy", 32'(par_busy), 1);
    repeat (8) cyc();
    chk("t1 end ser_valid", 32'(ser_valid), 0);
    chk("t1 end par_busy", 32'(par_busy), 0);
    chk("t1 all popped", 32'(sb.size()), 0);

    // 2: five-cycle stall on sample 3
    fill(20);
    par_valid = 1'b1;
    cyc();
    par_valid = 1'b0;
    repeat (3) cyc();
    ser_busy = 1'b1;
    repeat (5) cyc();
    chk("t2 frozen index", 32'(ser_index), 32'(order(3)));
    ser_busy = 1'b0;
    wait_drain("t2 drain");

    // 3: par_valid held across two blocks
    fill(40);
    p0 = n_pop; captures = 0; lows = 0;
    par_valid = 1'b1;
    for (int i = 0; i < 60 && captures < 2; i++) begin
      @(negedge clk);
      if (!par_busy) lows++;
      if (!par_busy) begin
        captures++;
        if (captures == 2) chk("t3 pops at 2nd capture", 32'(n_pop - p0), 8);
      end
      cyc();
      if (captures == 1) fill(60);
      if (captures == 2) par_valid = 1'b0;
    end
    chk("t3 captures", 32'(captures), 2);
    chk("t3 busy low cycles", 32'(lows), 2);
    wait_drain("t3 drain");
    chk("t3 samples", 32'(n_pop - p0), 16);

    // 4: asynchronous reset mid-block
    fill(80);
    par_valid = 1'b1;
    cyc();
    par_valid = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    chk("t4 par_busy", 32'(par_busy), 0);
    chk("t4 ser_valid", 32'(ser_valid), 0);
    chk("t4 ser_real", 32'(ser_real), 0);
    chk("t4 ser_imag", 32'(ser_imag), 0);
    chk("t4 ser_index", 32'(ser_index), 0);
    chk("t4 ser_last", 32'(ser_last), 0);
    sb.delete();
    cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    chk("t4 no ser_valid", 32'(ser_valid), 0);
    chk("t4 par_busy idle", 32'(par_busy), 0);

    // 5: stall on the last sample
    fill(100);
    par_valid = 1'b1;
    cyc();
    par_valid = 1'b0;
    repeat (7) cyc();
    ser_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5 ser_last held", 32'(ser_last), 1);
      chk("t5 ser_valid held", 32'(ser_valid), 1);
      chk("t5 par_busy held", 32'(par_busy), 1);
    end
    ser_busy = 1'b0;
    cyc();
    chk("t5 par_busy released", 32'(par_busy), 0);
    chk("t5 ser_valid cleared", 32'(ser_valid), 0);
    chk("t5 ser_last cleared", 32'(ser_last), 0);

    // 6: bus changes while busy, including an ignored offer
    fill(200);
    par_valid = 1'b1;
    cyc();
    fill(1000);
    repeat (4) cyc();
    par_valid = 1'b0;
    wait_drain("t6 drain");
    chk("t6 scoreboard empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
